led_pulse_ctrl: RTL and testbench

Multi-channel LED indicator driver, successor to the single-channel IR repeat-frame LED stretcher. Each channel detects rising edges of an asynchronous event input and drives its LED in one of three modes: fixed-length hold, retriggerable hold, or a burst of N blinks. It sits between the IR decoder status flags (repeat_en, data_valid, error, etc.) and the board LEDs.

---
 rtl/led_pulse_ctrl_if.sv | 13 +
 rtl/led_pulse_ctrl.sv | 155 +++++++++++++++
 tb/tb_led_pulse_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pulse_ctrl_if.sv
// Event/LED bundle for led_pulse_ctrl: per-channel triggers and global mode in,
// per-channel LED drives and busy flags out.
interface led_pulse_ctrl_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] trig;
    logic [1:0]        mode;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] busy;

    modport master (output trig, output mode, input led, input busy);
    modport slave  (input trig, input mode, output led, output busy);
endinterface

// File: rtl/led_pulse_ctrl.sv
// Multi-channel LED indicator driver: one-shot hold, retriggerable hold or blink burst
// per asynchronous event input. Optional PWM dimming is enabled by defining LED_DIM_EN.
module led_pulse_ctrl #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 23,
    parameter int HOLD_CYC       = 2500000,
    parameter int BLINK_HALF     = 1250000,
    parameter int BLINK_NUM      = 3,
    parameter bit LED_ACTIVE_LOW = 1'b1
`ifdef LED_DIM_EN
    ,
    parameter int DIM_DUTY       = 8
`endif
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    led_pulse_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [1:0]       MODE_RETRIG = 2'b01;
    localparam logic [1:0]       MODE_BLINK  = 2'b10;
    localparam logic [1:0]       MODE_OFF    = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] HOLD_LD     = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] BLINK_LD    = CNT_W'(BLINK_HALF);
    localparam logic [3:0]       BLINK_LAST  = 4'(BLINK_NUM - 1);
    localparam logic             LED_OFF     = LED_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic             LED_ON      = LED_ACTIVE_LOW ? 1'b0 : 1'b1;

    logic [NUM_CH-1:0] led_s;
    logic [NUM_CH-1:0] busy_s;
    logic              dim_gate_s;

`ifdef LED_DIM_EN
    logic [3:0] pwm_cnt_r;

    // Shared free-running PWM phase; a lit channel is driven only in the first DIM_DUTY slots.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt_r <= 4'd0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 4'd1;
        end
    end

    assign dim_gate_s = ({1'b0, pwm_cnt_r} < 5'(DIM_DUTY));
`else
    assign dim_gate_s = 1'b1;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             trig_d1_r;
        logic             trig_d2_r;
        logic             rise_s;
        state_t           state_r;
        logic [CNT_W-1:0] cnt_r;
        logic [3:0]       blink_r;
        logic [1:0]       mode_r;
        logic             led_r;
        logic             busy_r;

        // Two-stage synchroniser for the asynchronous event input.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                trig_d1_r <= 1'b0;
                trig_d2_r <= 1'b0;
            end else begin
                trig_d1_r <= bus.trig[g];
                trig_d2_r <= trig_d1_r;
            end
        end

        assign rise_s = trig_d1_r & ~trig_d2_r;

        // Channel sequencer; led/busy are registered from the pre-edge state so both lag it by one edge.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state_r <= ST_IDLE;
                cnt_r   <= CNT_ZERO;
                blink_r <= 4'd0;
                mode_r  <= 2'b00;
                led_r   <= LED_OFF;
                busy_r  <= 1'b0;
            end else if (bus.mode == MODE_OFF) begin
                state_r <= ST_IDLE;
                cnt_r   <= CNT_ZERO;
                blink_r <= 4'd0;
                mode_r  <= mode_r;
                led_r   <= LED_OFF;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (rise_s) begin
                            state_r <= ST_ON;
                            mode_r  <= bus.mode;
                            cnt_r   <= (bus.mode == MODE_BLINK) ? BLINK_LD : HOLD_LD;
                            blink_r <= 4'd0;
                        end else begin
                            state_r <= ST_IDLE;
                            cnt_r   <= CNT_ZERO;
                            blink_r <= 4'd0;
                        end
                    end
                    ST_ON: begin
                        // A retrigger reload outranks both the decrement and the end of hold.
                        if ((mode_r == MODE_RETRIG) && rise_s) begin
                            cnt_r <= HOLD_LD;
                        end else if (cnt_r == CNT_ONE) begin
                            if ((mode_r == MODE_BLINK) && (blink_r != BLINK_LAST)) begin
                                state_r <= ST_OFF;
                                cnt_r   <= BLINK_LD;
                            end else begin
                                state_r <= ST_IDLE;
                                cnt_r   <= CNT_ZERO;
                            end
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    ST_OFF: begin
                        if (cnt_r == CNT_ONE) begin
                            state_r <= ST_ON;
                            cnt_r   <= BLINK_LD;
                            blink_r <= blink_r + 4'd1;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                        blink_r <= 4'd0;
                    end
                endcase
                led_r  <= ((state_r == ST_ON) && dim_gate_s) ? LED_ON : LED_OFF;
                busy_r <= (state_r != ST_IDLE);
            end
        end

        assign led_s[g]  = led_r;
        assign busy_s[g] = busy_r;
    end

    assign bus.led  = led_s;
    assign bus.busy = busy_s;

endmodule

// File: tb/tb_led_pulse_ctrl.sv
// Scoreboard bench for led_pulse_ctrl: interval-based reference model feeds an expectation
// queue that a negedge monitor drains, plus directed checks from the test plan.
module tb_led_pulse_ctrl;
    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int HOLD = 10;
    localparam int HALF = 4;
    localparam int NBL  = 3;
`ifdef LED_DIM_EN
    localparam int DUTY = 4;
`endif

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    led_pulse_ctrl_if #(.NUM_CH(NCH)) bus ();

    led_pulse_ctrl #(
        .NUM_CH(NCH), .CNT_W(CW), .HOLD_CYC(HOLD), .BLINK_HALF(HALF),
        .BLINK_NUM(NBL), .LED_ACTIVE_LOW(1'b1)
`ifdef LED_DIM_EN
        , .DIM_DUTY(DUTY)
`endif
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] sb_q[$];

    // Reference model: each channel is one lit/busy interval [seq_s, seq_e) in output-sample indices.
    int         edge_n = 0;
    int         seq_s[NCH];
    int         seq_e[NCH];
    logic [1:0] seq_md[NCH];
    logic [NCH-1:0] hist1 = '0;
    logic [NCH-1:0] hist2 = '0;
    int         pwm_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    function automatic bit seq_busy(input int ch, input int idx);
        return (idx >= seq_s[ch]) && (idx < seq_e[ch]);
    endfunction

    function automatic bit seq_lit(input int ch, input int idx);
        return seq_busy(ch, idx) && ((seq_md[ch] != 2'b10) || ((((idx - seq_s[ch]) / HALF) % 2) == 0));
    endfunction

    task automatic model_step();
        logic [NCH-1:0] rise, exp_led, exp_busy;
        bit gate;
        if (!sys_rst_n) begin
            hist1 = '0;
            hist2 = '0;
            pwm_m = 0;
            for (int c = 0; c < NCH; c++) begin seq_s[c] = 0; seq_e[c] = 0; end
            exp_led  = {NCH{1'b1}};
            exp_busy = {NCH{1'b0}};
        end else begin
            rise = hist1 & ~hist2;
            if (bus.mode == 2'b11) begin
                for (int c = 0; c < NCH; c++) if (seq_e[c] > edge_n) seq_e[c] = edge_n;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (rise[c]) begin
                        if (!seq_busy(c, edge_n)) begin
                            seq_md[c] = bus.mode;
                            seq_s[c]  = edge_n + 1;
                            seq_e[c]  = seq_s[c] + ((bus.mode == 2'b10) ? (2 * NBL - 1) * HALF : HOLD);
                        end else if (seq_md[c] == 2'b01) begin
                            seq_e[c] = edge_n + 1 + HOLD;
                        end
                    end
                end
            end
            hist2 = hist1;
            hist1 = bus.trig;
            gate  = 1'b1;
`ifdef LED_DIM_EN
            gate  = (pwm_m < DUTY);
            pwm_m = (pwm_m + 1) % 16;
`endif
            for (int c = 0; c < NCH; c++) begin
                exp_busy[c] = seq_busy(c, edge_n);
                exp_led[c]  = !(seq_lit(c, edge_n) && gate);
            end
        end
        sb_q.push_back({exp_led, exp_busy});
        edge_n++;
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin seq_s[c] = 0; seq_e[c] = 0; seq_md[c] = 2'b00; end
        forever begin
            @(posedge sys_clk);
            model_step();
        end
    end

    // Monitor: compare every registered output sample against the queued expectation.
    initial begin
        logic [7:0] exp_v;
        forever begin
            @(negedge sys_clk);
            if (sb_q.size() != 0) begin
                exp_v = sb_q.pop_front();
                check("sb_led", 32'(bus.led), 32'(exp_v[7:4]));
                check("sb_busy", 32'(bus.busy), 32'(exp_v[3:0]));
            end
        end
    end

    task automatic tick();
        @(negedge sys_clk);
    endtask

    // Steps ncyc cycles after a trig was set, clearing it (re-pulsing at re_at) and profiling channel ch.
    task automatic run_count(input int ncyc, input int ch, input int re_at,
                             output int lit, output int bsy, output int first,
                             output int others, output logic [31:0] lit_vec);
        lit = 0; bsy = 0; first = -1; others = 0; lit_vec = '0;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge sys_clk);
            if (bus.led[ch] == 1'b0) begin
                lit++;
                if (first < 0) first = i;
                if (i < 32) lit_vec[i] = 1'b1;
            end
            if (bus.busy[ch]) bsy++;
            for (int c = 0; c < NCH; c++)
                if ((c != ch) && ((bus.led[c] == 1'b0) || bus.busy[c])) others++;
            bus.trig = (i == re_at) ? (4'b0001 << ch) : 4'b0000;
        end
    endtask

    initial begin
        int lit, bsy, first, others, mixed, all_lit, all_busy;
        logic [31:0] lv;
        logic [3:0] flip;
        bus.trig = 4'b0000;
        bus.mode = 2'b00;
        repeat (3) tick();
        check("reset_led", 32'(bus.led), 32'h0000000f);
        check("reset_busy", 32'(bus.busy), 32'h0);
        sys_rst_n = 1'b1;
        repeat (3) tick();

        // One-shot hold on channel 0.
        bus.trig = 4'b0001;
        run_count(20, 0, 0, lit, bsy, first, others, lv);
        check("oneshot_busy_len", 32'(bsy), 32'd10);
        check("oneshot_others", 32'(others), 32'd0);
`ifndef LED_DIM_EN
        check("oneshot_lit_len", 32'(lit), 32'd10);
        check("oneshot_latency", 32'(first), 32'd3);
`endif

        // Retrigger 6 cycles later extends the hold; the same stimulus in one-shot does not.
        bus.mode = 2'b01;
        tick();
        bus.trig = 4'b0010;
        run_count(30, 1, 6, lit, bsy, first, others, lv);
        check("retrig_busy_len", 32'(bsy), 32'd16);
`ifndef LED_DIM_EN
        check("retrig_lit_len", 32'(lit), 32'd16);
`endif
        bus.mode = 2'b00;
        tick();
        bus.trig = 4'b0010;
        run_count(30, 1, 6, lit, bsy, first, others, lv);
        check("noretrig_busy_len", 32'(bsy), 32'd10);
`ifndef LED_DIM_EN
        check("noretrig_lit_len", 32'(lit), 32'd10);
`endif

        // Blink burst on channel 2: 4 on / 4 off / 4 on / 4 off / 4 on.
        bus.mode = 2'b10;
        tick();
        bus.trig = 4'b0100;
        run_count(30, 2, 0, lit, bsy, first, others, lv);
        check("blink_busy_len", 32'(bsy), 32'd20);
`ifndef LED_DIM_EN
        check("blink_pattern", lv, 32'h00787878);
        check("blink_lit_len", 32'(lit), 32'd12);
`endif

        // Simultaneous rises on all channels.
        bus.mode = 2'b00;
        tick();
        bus.trig = 4'b1111;
        mixed = 0; all_lit = 0; all_busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            bus.trig = 4'b0000;
            if ((bus.led != 4'b0000) && (bus.led != 4'b1111)) mixed++;
            if (bus.led == 4'b0000) all_lit++;
            if (bus.busy == 4'b1111) all_busy++;
        end
        check("allch_mixed", 32'(mixed), 32'd0);
        check("allch_busy_len", 32'(all_busy), 32'd10);
`ifndef LED_DIM_EN
        check("allch_lit_len", 32'(all_lit), 32'd10);
`endif

        // Disable mid-burst, then a rise while disabled.
        bus.mode = 2'b10;
        bus.trig = 4'b0100;
        tick();
        bus.trig = 4'b0000;
        repeat (6) tick();
        check("burst_running", 32'(bus.busy[2]), 32'd1);
        bus.mode = 2'b11;
        tick();
        check("disable_led", 32'(bus.led), 32'h0000000f);
        check("disable_busy", 32'(bus.busy), 32'h0);
        bus.trig = 4'b0100;
        run_count(10, 2, 0, lit, bsy, first, others, lv);
        check("disable_drop_busy", 32'(bsy + others), 32'd0);
        bus.mode = 2'b00;
        repeat (3) tick();

        // Asynchronous reset mid-hold.
        bus.trig = 4'b0010;
        tick();
        bus.trig = 4'b0000;
        repeat (5) tick();
        check("hold_running", 32'(bus.busy[1]), 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(bus.led), 32'h0000000f);
        check("async_rst_busy", 32'(bus.busy), 32'h0);
        repeat (2) tick();
        sys_rst_n = 1'b1;
        run_count(15, 1, 0, lit, bsy, first, others, lv);
        check("no_resume", 32'(bsy + others), 32'd0);

        // Randomised traffic checked by the scoreboard.
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int c = 0; c < NCH; c++) flip[c] = ($urandom_range(0, 9) == 0);
            bus.trig = bus.trig ^ flip;
            if (bus.mode == 2'b11) begin
                if ($urandom_range(0, 7) == 0) bus.mode = 2'($urandom_range(0, 2));
            end else if ($urandom_range(0, 149) == 0) begin
                bus.mode = 2'b11;
            end else if ($urandom_range(0, 59) == 0) begin
                bus.mode = 2'($urandom_range(0, 2));
            end
        end
        bus.trig = 4'b0000;
        bus.mode = 2'b00;
        repeat (40) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
